// File: rtl/bram_pkg.sv
// Shared definitions for the CPU transmit buffer: data width, TXLEN field layout
// and the frame FSM state encoding.
package bram_pkg;

   localparam int DATA_W  = 32;
   localparam int TXLEN_W = 16;
   localparam int CNT_MSB = 15;
   localparam int CNT_LSB = 4;
   localparam int KEEP_W  = 4;
   localparam int CNT_W   = CNT_MSB - CNT_LSB + 1;
   localparam int TUSER_W = 64;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREFETCH = 2'd1,
      ST_SEND     = 2'd2,
      ST_DONE     = 2'd3
   } tx_state_e;

   // A zero keep field in TXLEN means a full last beat.
   function automatic logic [KEEP_W-1:0] norm_keep(input logic [KEEP_W-1:0] keep);
      return (keep == 4'h0) ? 4'hF : keep;
   endfunction

endpackage

// File: rtl/bram_tx_if.sv
// AXI4-Stream transmit channel between the CPU transmit buffer and the UDP/MAC path.
interface bram_tx_if;
   import bram_pkg::*;

   logic                tvalid;
   logic                tready;
   logic [DATA_W-1:0]   tdata;
   logic [KEEP_W-1:0]   tkeep;
   logic                tlast;
   logic [TUSER_W-1:0]  tuser;

   modport master (
      output tvalid, tdata, tkeep, tlast, tuser,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tkeep, tlast, tuser,
      output tready
   );

endinterface

// File: rtl/bram_sync_fifo.sv
// Single-clock FIFO with registered read data (one-cycle read latency) and
// occupancy count; stands in for the vendor FIFO core.
module bram_sync_fifo #(
   parameter int DW = 32,
   parameter int AW = 9
) (
   input  logic          sclk,
   input  logic          reset_n,
   input  logic          wr_en,
   input  logic [DW-1:0] wr_data,
   input  logic          rd_en,
   output logic [DW-1:0] rd_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0]   DEPTH   = {1'b1, {AW{1'b0}}};
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

   logic [DW-1:0] mem_r [0:(1<<AW)-1];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic [DW-1:0] rd_data_r;
   logic          wr_ok_s;
   logic          rd_ok_s;

   assign wr_ok_s = wr_en && !full;
   assign rd_ok_s = rd_en && !empty;

   // Storage array: no reset so it maps onto block RAM.
   always_ff @(posedge sclk) begin
      if (wr_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers, occupancy and registered read port.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         count_r   <= '0;
         rd_data_r <= '0;
      end else begin
         if (wr_ok_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (rd_ok_s) begin
            rd_ptr_r  <= rd_ptr_r + PTR_ONE;
            rd_data_r <= mem_r[rd_ptr_r];
         end
         case ({wr_ok_s, rd_ok_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   assign rd_data = rd_data_r;
   assign count   = count_r;
   assign full    = (count_r == DEPTH);
   assign empty   = (count_r == '0);

endmodule

// File: rtl/bram_tx.sv
// CPU transmit buffer: register writes fill a FIFO, a start strobe emits one
// AXI4-Stream frame of TXLEN words. Optional tuser side-band: BRAM_TX_TUSER_EN.
module bram_tx
   import bram_pkg::*;
#(
   parameter int FIFO_AW = 9
) (
   input  logic                 sclk,
   input  logic                 reset_n,
   input  logic                 tx_valid_i,
   input  logic [DATA_W-1:0]    tx_data_i,
   input  logic [TXLEN_W-1:0]   TXLEN_reg_i,
   input  logic                 tx_start_i,
   input  logic                 tx_int_enable_i,
   input  logic                 int_tx_clear_i,
   input  logic                 tx_error_clear_i,
   output logic                 INT_tx_o,
   output logic                 tx_error_o,
   output logic                 tx_busy_o,
   output logic [FIFO_AW:0]     tx_fill_o,
   bram_tx_if.master            axi_tx
);

   logic                fifo_full_s;
   logic                fifo_empty_s;
   logic [FIFO_AW:0]    fifo_count_s;
   logic [DATA_W-1:0]   fifo_rd_data_s;

   tx_state_e           state_r;
   tx_state_e           next_s;

   logic [CNT_W-1:0]    cnt_in_s;
   logic [KEEP_W-1:0]   keep_in_s;
   logic [31:0]         cnt_ext_s;
   logic [31:0]         fill_ext_s;
   logic [KEEP_W-1:0]   keep_r;
   logic [CNT_W-1:0]    beat_left_r;
   logic [CNT_W-1:0]    fetch_left_r;
   logic                nxt_valid_r;

   logic                out_valid_r;
   logic [DATA_W-1:0]   out_data_r;
   logic [KEEP_W-1:0]   out_keep_r;
   logic                out_last_r;

   logic                int_r;
   logic                err_r;
   logic                busy_r;

   logic                hs_s;
   logic                load_s;
   logic                load_last_s;
   logic                start_ok_s;
   logic                start_bad_s;
   logic                start_busy_s;
   logic                frame_end_s;
   logic                int_set_s;
   logic                err_set_s;
   logic                rd_en_s;

   bram_sync_fifo #(
      .DW (DATA_W),
      .AW (FIFO_AW)
   ) u_fifo (
      .sclk    (sclk),
      .reset_n (reset_n),
      .wr_en   (tx_valid_i),
      .wr_data (tx_data_i),
      .rd_en   (rd_en_s),
      .rd_data (fifo_rd_data_s),
      .full    (fifo_full_s),
      .empty   (fifo_empty_s),
      .count   (fifo_count_s)
   );

   assign cnt_in_s   = TXLEN_reg_i[CNT_MSB:CNT_LSB];
   assign keep_in_s  = norm_keep(TXLEN_reg_i[KEEP_W-1:0]);
   assign cnt_ext_s  = 32'(cnt_in_s);
   assign fill_ext_s = 32'(fifo_count_s);
   assign hs_s       = out_valid_r && axi_tx.tready;

   // Frame FSM next state and per-cycle control strobes.
   always_comb begin
      next_s       = state_r;
      load_s       = 1'b0;
      load_last_s  = 1'b0;
      start_ok_s   = 1'b0;
      start_bad_s  = 1'b0;
      start_busy_s = 1'b0;
      frame_end_s  = 1'b0;
      int_set_s    = 1'b0;
      rd_en_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (tx_start_i) begin
               if ((cnt_in_s == 12'd0) || (cnt_ext_s > fill_ext_s)) begin
                  start_bad_s = 1'b1;
               end else begin
                  start_ok_s = 1'b1;
                  next_s     = ST_PREFETCH;
               end
            end else begin
               next_s = ST_IDLE;
            end
         end
         ST_PREFETCH: begin
            start_busy_s = tx_start_i;
            load_s       = 1'b1;
            load_last_s  = (beat_left_r == 12'd1);
            next_s       = ST_SEND;
         end
         ST_SEND: begin
            start_busy_s = tx_start_i;
            if (hs_s) begin
               if (beat_left_r == 12'd1) begin
                  frame_end_s = 1'b1;
                  next_s      = ST_DONE;
               end else begin
                  load_s      = 1'b1;
                  load_last_s = (beat_left_r == 12'd2);
               end
            end else begin
               next_s = ST_SEND;
            end
         end
         ST_DONE: begin
            start_busy_s = tx_start_i;
            int_set_s    = tx_int_enable_i;
            next_s       = ST_IDLE;
         end
         default: begin
            next_s = ST_IDLE;
         end
      endcase
      // The FIFO read register doubles as a one-word read-ahead buffer.
      if (start_ok_s) begin
         rd_en_s = 1'b1;
      end else if (((state_r == ST_PREFETCH) || (state_r == ST_SEND)) &&
                   (fetch_left_r != 12'd0) && (!nxt_valid_r || load_s) &&
                   !fifo_empty_s) begin
         rd_en_s = 1'b1;
      end else begin
         rd_en_s = 1'b0;
      end
   end

   assign err_set_s = start_bad_s || start_busy_s || (tx_valid_i && fifo_full_s);

   // FSM state register and busy flag.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= next_s;
         busy_r  <= (next_s != ST_IDLE);
      end
   end

   // Frame bookkeeping: latched keep, beats still owed, words still to fetch.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         keep_r       <= 4'h0;
         beat_left_r  <= 12'd0;
         fetch_left_r <= 12'd0;
         nxt_valid_r  <= 1'b0;
      end else if (start_ok_s) begin
         keep_r       <= keep_in_s;
         beat_left_r  <= cnt_in_s;
         fetch_left_r <= cnt_in_s - 12'd1;
         nxt_valid_r  <= 1'b1;
      end else begin
         if (hs_s) begin
            beat_left_r <= beat_left_r - 12'd1;
         end
         if (rd_en_s) begin
            fetch_left_r <= fetch_left_r - 12'd1;
            nxt_valid_r  <= 1'b1;
         end else if (load_s) begin
            nxt_valid_r  <= 1'b0;
         end
      end
   end

   // Stream output register; holds steady while stalled.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_keep_r  <= 4'h0;
         out_last_r  <= 1'b0;
      end else if (load_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= fifo_rd_data_s;
         out_keep_r  <= load_last_s ? keep_r : 4'hF;
         out_last_r  <= load_last_s;
      end else if (frame_end_s) begin
         out_valid_r <= 1'b0;
         out_data_r  <= '0;
         out_keep_r  <= 4'h0;
         out_last_r  <= 1'b0;
      end
   end

   // Sticky interrupt and error flags; a set outranks a clear in the same cycle.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         int_r <= 1'b0;
         err_r <= 1'b0;
      end else begin
         if (int_set_s) begin
            int_r <= 1'b1;
         end else if (int_tx_clear_i) begin
            int_r <= 1'b0;
         end
         if (err_set_s) begin
            err_r <= 1'b1;
         end else if (tx_error_clear_i) begin
            err_r <= 1'b0;
         end
      end
   end

`ifdef BRAM_TX_TUSER_EN
   logic [CNT_W-1:0]   cnt_r;
   logic [TUSER_W-1:0] tuser_r;

   // Frame length copy that is replayed on tuser for every beat.
   always_ff @(posedge sclk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r   <= 12'd0;
         tuser_r <= 64'd0;
      end else begin
         if (start_ok_s) begin
            cnt_r <= cnt_in_s;
         end
         if (load_s) begin
            tuser_r <= {48'd0, cnt_r, keep_r};
         end else if (frame_end_s) begin
            tuser_r <= 64'd0;
         end
      end
   end

   assign axi_tx.tuser = tuser_r;
`else
   assign axi_tx.tuser = 64'd0;
`endif

   assign axi_tx.tvalid = out_valid_r;
   assign axi_tx.tdata  = out_data_r;
   assign axi_tx.tkeep  = out_keep_r;
   assign axi_tx.tlast  = out_last_r;

   assign INT_tx_o   = int_r;
   assign tx_error_o = err_r;
   assign tx_busy_o  = busy_r;
   assign tx_fill_o  = fifo_count_s;

endmodule

// File: tb/tb_bram_tx.sv
// Directed/randomised bench for bram_tx with a queue-based reference model.
module tb_bram_tx;

`ifdef BRAM_TX_TUSER_EN
   localparam bit TUSER_EN = 1'b1;
`else
   localparam bit TUSER_EN = 1'b0;
`endif

   logic        sclk = 1'b0;
   logic        reset_n;
   logic        tx_valid_i;
   logic [31:0] tx_data_i;
   logic [15:0] TXLEN_reg_i;
   logic        tx_start_i;
   logic        tx_int_enable_i;
   logic        int_tx_clear_i;
   logic        tx_error_clear_i;
   logic        INT_tx_o;
   logic        tx_error_o;
   logic        tx_busy_o;
   logic [9:0]  tx_fill_o;

   bram_tx_if axi_tx();

   always #5 sclk = ~sclk;

   bram_tx dut (
      .sclk             (sclk),
      .reset_n          (reset_n),
      .tx_valid_i       (tx_valid_i),
      .tx_data_i        (tx_data_i),
      .TXLEN_reg_i      (TXLEN_reg_i),
      .tx_start_i       (tx_start_i),
      .tx_int_enable_i  (tx_int_enable_i),
      .int_tx_clear_i   (int_tx_clear_i),
      .tx_error_clear_i (tx_error_clear_i),
      .INT_tx_o         (INT_tx_o),
      .tx_error_o       (tx_error_o),
      .tx_busy_o        (tx_busy_o),
      .tx_fill_o        (tx_fill_o),
      .axi_tx           (axi_tx)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model_q[$];
   logic [31:0] cap_data[$];
   logic [3:0]  cap_keep[$];
   logic        cap_last[$];
   logic [63:0] cap_tuser[$];

   int          valid_cycles = 0;
   int          stab_err     = 0;
   logic        prev_stall   = 1'b0;
   logic [31:0] prev_data    = 32'd0;
   logic [3:0]  prev_keep    = 4'd0;
   logic        prev_last    = 1'b0;
   logic [63:0] prev_tuser   = 64'd0;

   // Observe the stream in mid-cycle: record handshakes and stall stability.
   always @(negedge sclk) begin
      if (reset_n && axi_tx.tvalid) valid_cycles <= valid_cycles + 1;
      if (reset_n && axi_tx.tvalid && axi_tx.tready) begin
         cap_data.push_back(axi_tx.tdata);
         cap_keep.push_back(axi_tx.tkeep);
         cap_last.push_back(axi_tx.tlast);
         cap_tuser.push_back(axi_tx.tuser);
      end
      if (reset_n && prev_stall &&
          ((axi_tx.tvalid !== 1'b1) || (axi_tx.tdata !== prev_data) ||
           (axi_tx.tkeep !== prev_keep) || (axi_tx.tlast !== prev_last) ||
           (axi_tx.tuser !== prev_tuser)))
         stab_err <= stab_err + 1;
      prev_stall <= reset_n && axi_tx.tvalid && !axi_tx.tready;
      prev_data  <= axi_tx.tdata;
      prev_keep  <= axi_tx.tkeep;
      prev_last  <= axi_tx.tlast;
      prev_tuser <= axi_tx.tuser;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge sclk);
      #1;
   endtask

   task automatic cpu_write(input logic [31:0] d);
      tx_valid_i = 1'b1;
      tx_data_i  = d;
      step();
      tx_valid_i = 1'b0;
      if (model_q.size() < 512) model_q.push_back(d);
   endtask

   // mode 0: tready always high; 1: pattern 1,0,0; 2: random. poke: start again mid-frame.
   task automatic send_frame(input logic [15:0] txlen, input int mode, input bit poke);
      int          cnt;
      int          vc0;
      bit          done;
      logic [3:0]  keepn;
      logic [63:0] exp_tuser;
      logic [31:0] exp_q[$];
      cnt       = int'(txlen[15:4]);
      keepn     = (txlen[3:0] == 4'h0) ? 4'hF : txlen[3:0];
      exp_tuser = TUSER_EN ? {48'd0, txlen[15:4], keepn} : 64'd0;
      for (int i = 0; i < cnt; i++) exp_q.push_back(model_q.pop_front());
      cap_data.delete(); cap_keep.delete(); cap_last.delete(); cap_tuser.delete();
      vc0           = valid_cycles;
      TXLEN_reg_i   = txlen;
      axi_tx.tready = (mode == 0);
      tx_start_i    = 1'b1;
      step();
      tx_start_i = 1'b0;
      check("tvalid_at_start+1", axi_tx.tvalid, 1'b0);
      check("busy_at_start+1", tx_busy_o, 1'b1);
      done = 1'b0;
      for (int c = 0; c < 4000 && !done; c++) begin
         case (mode)
            0:       axi_tx.tready = 1'b1;
            1:       axi_tx.tready = ((c % 3) == 0);
            default: axi_tx.tready = 1'($urandom_range(0, 1));
         endcase
         tx_start_i = poke && (c == 1);
         step();
         if (c == 0) check("tvalid_at_start+2", axi_tx.tvalid, 1'b1);
         done = (cap_data.size() == cnt) && !tx_busy_o;
      end
      tx_start_i = 1'b0;
      check("frame_timeout", done, 1'b1);
      check("beat_count", cap_data.size(), cnt);
      if (mode == 0) check("no_bubbles", valid_cycles - vc0, cnt);
      for (int i = 0; i < cnt && i < cap_data.size(); i++) begin
         check("tdata", cap_data[i], exp_q[i]);
         check("tkeep", cap_keep[i], (i == cnt - 1) ? keepn : 4'hF);
         check("tlast", cap_last[i], (i == cnt - 1));
         check("tuser", cap_tuser[i], exp_tuser);
      end
      check("tuser_idle", axi_tx.tuser, 64'd0);
   endtask

   initial begin
      reset_n = 1'b0; tx_valid_i = 1'b0; tx_data_i = 32'd0; TXLEN_reg_i = 16'd0;
      tx_start_i = 1'b0; tx_int_enable_i = 1'b0; int_tx_clear_i = 1'b0;
      tx_error_clear_i = 1'b0; axi_tx.tready = 1'b0;
      step(); step();
      check("rst_tvalid", axi_tx.tvalid, 1'b0);
      check("rst_int", INT_tx_o, 1'b0);
      check("rst_err", tx_error_o, 1'b0);
      check("rst_busy", tx_busy_o, 1'b0);
      check("rst_fill", tx_fill_o, 10'd0);
      check("rst_tuser", axi_tx.tuser, 64'd0);
      reset_n = 1'b1;
      step();
      tx_int_enable_i = 1'b1;

      // Basic 3-word frame, full throughput.
      cpu_write(32'h11); cpu_write(32'h22); cpu_write(32'h33);
      check("fill_after_3", tx_fill_o, 10'd3);
      send_frame(16'h003C, 0, 1'b0);
      check("int_set", INT_tx_o, 1'b1);
      check("fill_after_frame", tx_fill_o, 10'd0);
      int_tx_clear_i = 1'b1; step(); int_tx_clear_i = 1'b0;
      check("int_cleared", INT_tx_o, 1'b0);

      // Same frame with back-pressure 1,0,0,...
      cpu_write(32'h11); cpu_write(32'h22); cpu_write(32'h33);
      send_frame(16'h003C, 1, 1'b0);
      check("int_set_stalled", INT_tx_o, 1'b1);

      // Interrupt clear held through the frame: set wins on the final cycle.
      int_tx_clear_i = 1'b1;
      cpu_write($urandom); cpu_write($urandom);
      send_frame(16'h0021, 0, 1'b0);
      check("int_set_beats_clear", INT_tx_o, 1'b1);
      step();
      int_tx_clear_i = 1'b0;
      check("int_clear_after", INT_tx_o, 1'b0);

      // Extra words stay queued; start while busy flags an error; keep 0 -> F.
      for (int i = 0; i < 5; i++) cpu_write($urandom);
      check("err_before_poke", tx_error_o, 1'b0);
      send_frame(16'h0030, 2, 1'b1);
      check("err_start_busy", tx_error_o, 1'b1);
      check("fill_leftover", tx_fill_o, 10'd2);
      tx_error_clear_i = 1'b1; step(); tx_error_clear_i = 1'b0;
      check("err_cleared", tx_error_o, 1'b0);

      // Length larger than fill: rejected, nothing emitted.
      TXLEN_reg_i = 16'h0050; tx_start_i = 1'b1; axi_tx.tready = 1'b1;
      step(); tx_start_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("no_tvalid_on_bad_len", axi_tx.tvalid, 1'b0);
      end
      check("err_bad_len", tx_error_o, 1'b1);
      check("fill_kept", tx_fill_o, 10'd2);
      check("busy_bad_len", tx_busy_o, 1'b0);
      tx_error_clear_i = 1'b1; step(); tx_error_clear_i = 1'b0;
      check("err_cleared2", tx_error_o, 1'b0);

      // Zero count also rejected.
      TXLEN_reg_i = 16'h000F; tx_start_i = 1'b1; step(); tx_start_i = 1'b0; step();
      check("err_zero_cnt", tx_error_o, 1'b1);
      check("busy_zero_cnt", tx_busy_o, 1'b0);
      tx_error_clear_i = 1'b1; step(); tx_error_clear_i = 1'b0;

      // Drain the two leftovers with random back-pressure.
      send_frame(16'h0022, 2, 1'b0);
      check("fill_drained", tx_fill_o, 10'd0);

      // Overfill: 513 writes, last one dropped.
      for (int i = 0; i < 513; i++) cpu_write(32'(i));
      check("fill_full", tx_fill_o, 10'd512);
      check("err_overflow", tx_error_o, 1'b1);
      tx_valid_i = 1'b1; tx_data_i = 32'hDEAD; tx_error_clear_i = 1'b1;
      step();
      tx_valid_i = 1'b0; tx_error_clear_i = 1'b0;
      check("err_set_beats_clear", tx_error_o, 1'b1);
      tx_error_clear_i = 1'b1; step(); tx_error_clear_i = 1'b0;
      check("err_cleared3", tx_error_o, 1'b0);
      send_frame(16'h2000, 2, 1'b0);
      check("fill_after_512", tx_fill_o, 10'd0);
      check("int_before_reset", INT_tx_o, 1'b1);

      // Reset at beat 2 of 4.
      for (int i = 0; i < 4; i++) cpu_write($urandom);
      TXLEN_reg_i = 16'h0040; axi_tx.tready = 1'b1; tx_start_i = 1'b1;
      step(); tx_start_i = 1'b0;
      step(); step();
      check("beat2_presented", axi_tx.tvalid, 1'b1);
      reset_n = 1'b0;
      #1;
      check("rst_mid_tvalid", axi_tx.tvalid, 1'b0);
      check("rst_mid_int", INT_tx_o, 1'b0);
      check("rst_mid_fill", tx_fill_o, 10'd0);
      model_q.delete();
      step();
      reset_n = 1'b1;
      step(); step();
      check("post_rst_tvalid", axi_tx.tvalid, 1'b0);
      check("post_rst_busy", tx_busy_o, 1'b0);
      check("post_rst_err", tx_error_o, 1'b0);
      check("post_rst_int", INT_tx_o, 1'b0);

      // Normal operation resumes after reset.
      cpu_write($urandom); cpu_write($urandom);
      send_frame(16'h0024, 0, 1'b0);
      check("stall_stability", stab_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
